fetch_stage: RTL

Instruction fetch stage of the single-issue MIPS pipeline. Holds the PC, runs a request/ready handshake to instruction memory, and drives the IF/ID register whose `instr` output feeds the main decoder. Redirects come from two places: taken branches resolved in EX (`branch_taken`) and the decoder's `jump` output for the word currently in IF/ID. A one-entry skid buffer and a drain state ensure no fetched word is lost or duplicated across stalls and redirects.

---
 rtl/fetch_stage.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : MIPS IF stage (PC, imem handshake, IF/ID register, redirects)
// Optional FETCH_STATS_EN adds fetch_count / flush_count.  Rev 1.0
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  localparam logic [1:0] c_st_fetch = 2'd0;
  localparam logic [1:0] c_st_drain = 2'd1;
  localparam logic [1:0] c_st_buf   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_inc;
  logic        w_if_load;

  // A jump is only honoured for a real, non-stalled IF/ID word; branches always win.
  assign w_redirect = branch_taken | (jump & valid_q & ~stall);
  assign w_target   = branch_taken ? branch_target
                                   : {pc4_q[31:28], instr_q[25:0], 2'b00};
  assign w_pc_inc   = pc_q + 32'd4;

  assign imem_req    = ~rst & (state_q != c_st_buf);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign pc_plus4    = pc4_q;
  assign instr_valid = valid_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    w_if_load   = 1'b0;

    if (w_redirect) begin
      instr_d = 32'd0;
      valid_d = 1'b0;
    end

    case (state_q)
      c_st_fetch: begin
        if (imem_ready) begin
          if (w_redirect) begin
            pc_d = w_target;
          end else if (!stall) begin
            instr_d   = imem_rdata;
            pc4_d     = w_pc_inc;
            valid_d   = 1'b1;
            w_if_load = 1'b1;
            pc_d      = w_pc_inc;
          end else begin
            buf_instr_d = imem_rdata;
            buf_pc4_d   = w_pc_inc;
            pc_d        = w_pc_inc;
            state_d     = c_st_buf;
          end
        end else if (w_redirect) begin
          pend_d  = w_target;
          state_d = c_st_drain;
        end else if (!stall) begin
          instr_d = 32'd0;
          valid_d = 1'b0;
        end
      end

      c_st_drain: begin
        // The outstanding word belongs to the wrong path; wait it out, then discard.
        instr_d = 32'd0;
        valid_d = 1'b0;
        if (w_redirect) begin
          pend_d = w_target;
        end
        if (imem_ready) begin
          pc_d    = w_redirect ? w_target : pend_q;
          state_d = c_st_fetch;
        end
      end

      c_st_buf: begin
        if (w_redirect) begin
          pc_d    = w_target;
          state_d = c_st_fetch;
        end else if (!stall) begin
          instr_d   = buf_instr_q;
          pc4_d     = buf_pc4_q;
          valid_d   = 1'b1;
          w_if_load = 1'b1;
          state_d   = c_st_fetch;
        end
      end

      default: begin
        state_d = c_st_fetch;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= c_st_fetch;
      pc_q        <= RESET_PC;
      pend_q      <= 32'd0;
      buf_instr_q <= 32'd0;
      buf_pc4_q   <= 32'd0;
      instr_q     <= 32'd0;
      pc4_q       <= 32'd0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (w_if_load) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (w_redirect) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  logic w_unused_load;
  assign w_unused_load = w_if_load;
`endif

endmodule
`default_nettype wire
